// File: rtl/fifo_ring_ram.sv
// Storage ring behind the FIFO output register: one write port, one
// asynchronous read port, so it maps onto distributed RAM.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module fifo_ring_ram #(
  parameter integer WIDTH = 8,
  parameter integer DEPTH = 3,
  parameter integer AW    = 2
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

`ifndef BSV_NO_INITIAL_BLOCKS
  localparam logic [2*WIDTH-1:0] AA_REP = {WIDTH{2'b10}};
  localparam logic [WIDTH-1:0]   AA_PAT = AA_REP[WIDTH-1:0];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = AA_PAT;
  end
`endif

  // Single write port: at most one entry written per cycle.
  always @(posedge CLK) begin
    if (we) mem_q[waddr] <= `BSV_ASSIGNMENT_DELAY wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sized_fifol_level.sv
// Sized FIFO with a registered output stage, loopy FULL_N, a registered
// occupancy count with almost-full flag, and sticky overflow/underflow flags.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

module sized_fifol_level #(
  parameter integer p1width      = 8,
  parameter integer p2depth      = 4,
  parameter integer p3cntr_width = 2,
  parameter integer p4lvl_width  = 3,
  parameter integer p5afull      = p2depth - 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   CLR,
  input  logic [p1width-1:0]     D_IN,
  input  logic                   ENQ,
  output logic                   FULL_N,
  output logic [p1width-1:0]     D_OUT,
  input  logic                   DEQ,
  output logic                   EMPTY_N,
  output logic [p4lvl_width-1:0] LEVEL,
  output logic                   AFULL,
  output logic                   OVF,
  output logic                   UNF
);

  localparam integer RING_DEPTH = p2depth - 1;
  localparam logic [p3cntr_width-1:0] PTR_LAST  = p3cntr_width'(p2depth - 2);
  localparam logic [p4lvl_width-1:0]  LVL_MAX   = p4lvl_width'(p2depth);
  localparam logic [p4lvl_width-1:0]  AFULL_LVL = p4lvl_width'(p5afull);

  function automatic logic [p3cntr_width-1:0] ptr_inc(input logic [p3cntr_width-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [p1width-1:0]      d_out_q, d_out_d;
  logic                    empty_n_q, empty_n_d;
  logic [p3cntr_width-1:0] head_q, head_d;
  logic [p3cntr_width-1:0] tail_q, tail_d;
  logic                    ring_full_q, ring_full_d;
  logic                    ring_empty_q, ring_empty_d;
  logic [p4lvl_width-1:0]  level_q, level_d;
  logic                    afull_q, afull_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;

  logic                    full_n;
  logic                    enq_ok, deq_ok;
  logic                    ring_we;
  logic [p1width-1:0]      ring_rdata;
  logic [p3cntr_width-1:0] head_inc, tail_inc;

  fifo_ring_ram #(
    .WIDTH (p1width),
    .DEPTH (RING_DEPTH),
    .AW    (p3cntr_width)
  ) u_ring (
    .CLK   (CLK),
    .we    (ring_we && RST_N),
    .waddr (tail_q),
    .wdata (D_IN),
    .raddr (head_q),
    .rdata (ring_rdata)
  );

  // Loopy full: a simultaneous dequeue frees the slot the enqueue needs.
  assign full_n   = (level_q != LVL_MAX) || DEQ;
  assign enq_ok   = ENQ && full_n;
  assign deq_ok   = DEQ && empty_n_q;
  assign head_inc = ptr_inc(head_q);
  assign tail_inc = ptr_inc(tail_q);

  // Next-state: clear, then output-register / ring moves and level update.
  always_comb begin
    d_out_d      = d_out_q;
    empty_n_d    = empty_n_q;
    head_d       = head_q;
    tail_d       = tail_q;
    ring_full_d  = ring_full_q;
    ring_empty_d = ring_empty_q;
    level_d      = level_q;
    afull_d      = afull_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    ring_we      = 1'b0;
    if (CLR) begin
      empty_n_d    = 1'b0;
      head_d       = '0;
      tail_d       = '0;
      ring_full_d  = 1'b0;
      ring_empty_d = 1'b1;
      level_d      = '0;
      afull_d      = 1'b0;
      ovf_d        = 1'b0;
      unf_d        = 1'b0;
    end else begin
      if (ENQ && !full_n)    ovf_d = 1'b1;
      if (DEQ && !empty_n_q) unf_d = 1'b1;
      case ({enq_ok, deq_ok})
        2'b10: begin
          if (!empty_n_q) begin
            d_out_d   = D_IN;
            empty_n_d = 1'b1;
          end else if (!ring_full_q) begin
            ring_we      = 1'b1;
            tail_d       = tail_inc;
            ring_empty_d = 1'b0;
            ring_full_d  = (tail_inc == head_q);
          end
        end
        2'b01: begin
          if (ring_empty_q) begin
            empty_n_d = 1'b0;
          end else begin
            d_out_d      = ring_rdata;
            head_d       = head_inc;
            ring_full_d  = 1'b0;
            ring_empty_d = (head_inc == tail_q);
          end
        end
        2'b11: begin
          if (ring_empty_q) begin
            d_out_d = D_IN;
          end else begin
            ring_we = 1'b1;
            tail_d  = tail_inc;
            d_out_d = ring_rdata;
            head_d  = head_inc;
          end
        end
        default: ;
      endcase
      if (enq_ok && !deq_ok && level_q != LVL_MAX)
        level_d = level_q + 1'b1;
      else if (deq_ok && !enq_ok && level_q != '0)
        level_d = level_q - 1'b1;
      afull_d = (level_d >= AFULL_LVL);
    end
  end

  // Control state: synchronous active-low reset wins over everything.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      empty_n_q    <= `BSV_ASSIGNMENT_DELAY 1'b0;
      head_q       <= `BSV_ASSIGNMENT_DELAY '0;
      tail_q       <= `BSV_ASSIGNMENT_DELAY '0;
      ring_full_q  <= `BSV_ASSIGNMENT_DELAY 1'b0;
      ring_empty_q <= `BSV_ASSIGNMENT_DELAY 1'b1;
      level_q      <= `BSV_ASSIGNMENT_DELAY '0;
      afull_q      <= `BSV_ASSIGNMENT_DELAY (p5afull == 0);
      ovf_q        <= `BSV_ASSIGNMENT_DELAY 1'b0;
      unf_q        <= `BSV_ASSIGNMENT_DELAY 1'b0;
    end else begin
      empty_n_q    <= `BSV_ASSIGNMENT_DELAY empty_n_d;
      head_q       <= `BSV_ASSIGNMENT_DELAY head_d;
      tail_q       <= `BSV_ASSIGNMENT_DELAY tail_d;
      ring_full_q  <= `BSV_ASSIGNMENT_DELAY ring_full_d;
      ring_empty_q <= `BSV_ASSIGNMENT_DELAY ring_empty_d;
      level_q      <= `BSV_ASSIGNMENT_DELAY level_d;
      afull_q      <= `BSV_ASSIGNMENT_DELAY afull_d;
      ovf_q        <= `BSV_ASSIGNMENT_DELAY ovf_d;
      unf_q        <= `BSV_ASSIGNMENT_DELAY unf_d;
    end
  end

`ifndef BSV_NO_INITIAL_BLOCKS
  localparam logic [2*p1width-1:0] AA_REP = {p1width{2'b10}};
  localparam logic [p1width-1:0]   AA_PAT = AA_REP[p1width-1:0];
  initial d_out_q = AA_PAT;
`endif

  // Output data register: never reset, only meaningful while EMPTY_N is high.
  always @(posedge CLK) begin
    d_out_q <= `BSV_ASSIGNMENT_DELAY d_out_d;
  end

  assign FULL_N  = full_n;
  assign D_OUT   = d_out_q;
  assign EMPTY_N = empty_n_q;
  assign LEVEL   = level_q;
  assign AFULL   = afull_q;
  assign OVF     = ovf_q;
  assign UNF     = unf_q;

`ifndef SYNTHESIS
  initial begin
    if (p2depth < 3 || p3cntr_width < $clog2(p2depth - 1) ||
        p4lvl_width < $clog2(p2depth + 1) || p5afull < 1 || p5afull > p2depth) begin
      $display("Error: %m: illegal parameters depth=%0d cntr_width=%0d lvl_width=%0d afull=%0d",
               p2depth, p3cntr_width, p4lvl_width, p5afull);
      $finish;
    end
  end

  // Usage warnings for protocol violations by the surrounding logic.
  always @(posedge CLK) begin
    if (RST_N && !CLR) begin
      if (ENQ && !full_n)    $display("Warning: %m: enqueue to full fifo");
      if (DEQ && !empty_n_q) $display("Warning: %m: dequeue from empty fifo");
    end
  end
`endif

endmodule

// File: tb/tb_sized_fifol_level.sv
// Randomized and directed bench for sized_fifol_level against a queue model.
module tb_sized_fifol_level;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] D_IN = 8'h00;
  logic       ENQ = 1'b0;
  logic       DEQ = 1'b0;
  logic       FULL_N;
  logic [7:0] D_OUT;
  logic       EMPTY_N;
  logic [2:0] LEVEL;
  logic       AFULL;
  logic       OVF;
  logic       UNF;

  sized_fifol_level #(
    .p1width      (8),
    .p2depth      (4),
    .p3cntr_width (2),
    .p4lvl_width  (3),
    .p5afull      (3)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .CLR     (CLR),
    .D_IN    (D_IN),
    .ENQ     (ENQ),
    .FULL_N  (FULL_N),
    .D_OUT   (D_OUT),
    .DEQ     (DEQ),
    .EMPTY_N (EMPTY_N),
    .LEVEL   (LEVEL),
    .AFULL   (AFULL),
    .OVF     (OVF),
    .UNF     (UNF)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents in order, plus the two sticky flags.
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  int         seen_66 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check loopy FULL_N, clock, advance model, check outputs.
  task automatic cyc(input bit rst_n, input bit clr, input bit enq, input bit deq,
                     input logic [7:0] din);
    bit full, e_ok, d_ok;
    RST_N = rst_n; CLR = clr; ENQ = enq; DEQ = deq; D_IN = din;
    #3;
    if (rst_n) chk("full_n", {31'd0, FULL_N}, {31'd0, (mq.size() != 4) || deq});
    @(posedge CLK);
    if (!rst_n || clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      full = (mq.size() == 4);
      e_ok = enq && (!full || deq);
      d_ok = deq && (mq.size() != 0);
      if (enq && !e_ok) m_ovf = 1'b1;
      if (deq && !d_ok) m_unf = 1'b1;
      if (d_ok) void'(mq.pop_front());
      if (e_ok) mq.push_back(din);
    end
    #1;
    chk("empty_n", {31'd0, EMPTY_N}, {31'd0, mq.size() != 0});
    chk("level",   {29'd0, LEVEL},   mq.size());
    chk("afull",   {31'd0, AFULL},   {31'd0, mq.size() >= 3});
    chk("ovf",     {31'd0, OVF},     {31'd0, m_ovf});
    chk("unf",     {31'd0, UNF},     {31'd0, m_unf});
    if (mq.size() != 0) chk("d_out", {24'd0, D_OUT}, {24'd0, mq[0]});
    if (EMPTY_N === 1'b1 && D_OUT === 8'h66) seen_66++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e, d;
    // Reset
    cyc(0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    chk("rst_level", {29'd0, LEVEL}, 32'd0);

    // Fill: 0x11..0x44
    cyc(1, 0, 1, 0, 8'h11);
    chk("fill_dout_first", {24'd0, D_OUT}, 32'h11);
    cyc(1, 0, 1, 0, 8'h22);
    cyc(1, 0, 1, 0, 8'h33);
    chk("fill_afull_l3", {31'd0, AFULL}, 32'd1);
    cyc(1, 0, 1, 0, 8'h44);
    chk("fill_level4", {29'd0, LEVEL}, 32'd4);

    // Full, ENQ+DEQ 0x55 accepted, then drain
    cyc(1, 0, 1, 1, 8'h55);
    chk("full_both_dout", {24'd0, D_OUT}, 32'h22);
    chk("full_both_ovf", {31'd0, OVF}, 32'd0);
    cyc(1, 0, 0, 1, 8'h00);
    cyc(1, 0, 0, 1, 8'h00);
    cyc(1, 0, 0, 1, 8'h00);
    chk("drain_last", {24'd0, D_OUT}, 32'h55);
    cyc(1, 0, 0, 1, 8'h00);
    chk("drain_empty", {31'd0, EMPTY_N}, 32'd0);

    // Overflow on full, 0x66 must never show up, then CLR (with ENQ) clears
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 8'hA0 + 8'(i));
    cyc(1, 0, 1, 0, 8'h66);
    chk("ovf_set", {31'd0, OVF}, 32'd1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 8'h00);
    chk("ovf_no_66", seen_66, 32'd0);
    cyc(1, 0, 1, 0, 8'h12);
    cyc(1, 1, 1, 1, 8'h13);
    chk("clr_ovf", {31'd0, OVF}, 32'd0);

    // Underflow on empty, then ENQ+DEQ at level 1
    cyc(1, 0, 0, 1, 8'h00);
    chk("unf_set", {31'd0, UNF}, 32'd1);
    cyc(1, 0, 1, 0, 8'h70);
    cyc(1, 0, 1, 1, 8'h77);
    chk("lvl1_both_dout", {24'd0, D_OUT}, 32'h77);
    cyc(1, 1, 0, 0, 8'h00);

    // ENQ+DEQ on empty: the dequeue is illegal, the enqueue still lands
    cyc(1, 0, 1, 1, 8'h5A);
    cyc(1, 1, 0, 0, 8'h00);

    // Random legal traffic
    for (int i = 0; i < 300; i++) begin
      e = ($urandom_range(0, 99) < 55);
      d = ($urandom_range(0, 99) < 45);
      if (mq.size() == 0) d = 1'b0;
      if (mq.size() == 4 && !d) e = 1'b0;
      cyc(1, 0, e, d, 8'($urandom));
    end

    // Random traffic including illegal strobes and occasional clears
    for (int i = 0; i < 200; i++) begin
      cyc(1, ($urandom_range(0, 99) < 4), $urandom_range(0, 1), $urandom_range(0, 1),
          8'($urandom));
    end

    // Reset at level 3 with ENQ asserted
    cyc(1, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 8'hC0 + 8'(i));
    cyc(0, 0, 1, 0, 8'hCF);
    chk("rst_mid_level", {29'd0, LEVEL}, 32'd0);
    chk("rst_mid_afull", {31'd0, AFULL}, 32'd0);
    cyc(1, 0, 1, 0, 8'hD1);
    chk("post_rst_dout", {24'd0, D_OUT}, 32'hD1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
